cnn_conv3x3_engine: RTL and testbench

- Consumes the 3x3 pixel window and window-valid strobe produced by the CNN line buffer. Computes one signed 3x3 convolution per valid window.
- Output path: bias add, ReLU, right shift and saturation to an 8-bit feature-map pixel.
- Kernel weights and bias are loaded serially through a config port into shadow registers and committed atomically. Reloading never corrupts in-flight results.
- Sits between the line buffer and the pooling / feature-map writeback stage.

---
 rtl/cnn_conv3x3_engine_if.sv | 27 ++
 rtl/cnn_conv3x3_engine.sv | 131 +++++++++++++
 tb/tb_cnn_conv3x3_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_conv3x3_engine_if.sv
// Handshake bundle between the line buffer / config master and the 3x3 convolution engine.
// The master drives config words and windows; the slave returns status and output pixels.
interface cnn_conv3x3_engine_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8
);
    logic                           cfg_start;
    logic                           cfg_valid;
    logic signed [WEIGHT_WIDTH-1:0] cfg_data;
    logic                           cfg_done;
    logic                           loading;
    logic [9*DATA_WIDTH-1:0]        win_in;
    logic                           win_valid;
    logic [DATA_WIDTH-1:0]          pix_out;
    logic                           pix_valid;
    logic [15:0]                    drop_cnt;

    modport master (
        output cfg_start, cfg_valid, cfg_data, win_in, win_valid,
        input  cfg_done, loading, pix_out, pix_valid, drop_cnt
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, win_in, win_valid,
        output cfg_done, loading, pix_out, pix_valid, drop_cnt
    );
endinterface

// File: rtl/cnn_conv3x3_engine.sv
// Signed 3x3 convolution with bias, ReLU, requantize shift and 8-bit saturation.
// Coefficients load serially into shadow registers and commit atomically on the bias word.
module cnn_conv3x3_engine #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned OUT_SHIFT    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cnn_conv3x3_engine_if.slave  io_bus
);
    localparam int unsigned ACC_WIDTH  = DATA_WIDTH + WEIGHT_WIDTH + 5;
    localparam int unsigned PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] PIX_MAX = ACC_WIDTH'((2 ** DATA_WIDTH) - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]                     r_state;
    logic [3:0]                     r_idx;
    logic signed [WEIGHT_WIDTH-1:0] r_shadow [9];
    logic signed [WEIGHT_WIDTH-1:0] r_act_w  [9];
    logic signed [WEIGHT_WIDTH-1:0] r_act_b;
    logic                           r_cfg_done;
    logic [15:0]                    r_drop_cnt;

    logic signed [PROD_WIDTH-1:0]   r_prod [9];
    logic signed [WEIGHT_WIDTH-1:0] r_bias_s1;
    logic                           r_v1;
    logic signed [ACC_WIDTH-1:0]    r_sum;
    logic                           r_v2;
    logic signed [ACC_WIDTH-1:0]    r_relu;
    logic                           r_v3;
    logic [DATA_WIDTH-1:0]          r_pix;
    logic                           r_pv;

    logic                           w_accept;
    logic signed [PROD_WIDTH-1:0]   w_prod [9];
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]    w_relu;
    logic [DATA_WIDTH-1:0]          w_sat;

    assign w_accept = io_bus.win_valid && r_cfg_done;

    // Config FSM: the bias word copies shadow weights and itself into the active set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_act_b    <= '0;
            r_cfg_done <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_shadow[k] <= '0;
                r_act_w[k]  <= '0;
            end
        end else if (io_bus.cfg_start) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
        end else if (r_state == ST_LOAD && io_bus.cfg_valid) begin
            if (r_idx == 4'd9) begin
                for (int k = 0; k < 9; k++) begin
                    r_act_w[k] <= r_shadow[k];
                end
                r_act_b    <= io_bus.cfg_data;
                r_cfg_done <= 1'b1;
                r_state    <= ST_IDLE;
            end else begin
                r_shadow[r_idx] <= io_bus.cfg_data;
                r_idx           <= r_idx + 4'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = $signed({{(WEIGHT_WIDTH + 1){1'b0}},
                                 io_bus.win_in[k*DATA_WIDTH +: DATA_WIDTH]})
                      * $signed({{(DATA_WIDTH + 1){r_act_w[k][WEIGHT_WIDTH-1]}}, r_act_w[k]});
        end
    end

    always_comb begin
        w_sum = {{(ACC_WIDTH - WEIGHT_WIDTH){r_bias_s1[WEIGHT_WIDTH-1]}}, r_bias_s1};
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + {{(ACC_WIDTH - PROD_WIDTH){r_prod[k][PROD_WIDTH-1]}}, r_prod[k]};
        end
    end

    always_comb begin
        w_relu = r_sum[ACC_WIDTH-1] ? '0 : (r_sum >>> OUT_SHIFT);
        w_sat  = (r_relu > PIX_MAX) ? '1 : r_relu[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bias_s1  <= '0;
            r_v1       <= 1'b0;
            r_sum      <= '0;
            r_v2       <= 1'b0;
            r_relu     <= '0;
            r_v3       <= 1'b0;
            r_pix      <= '0;
            r_pv       <= 1'b0;
            r_drop_cnt <= '0;
            for (int k = 0; k < 9; k++) begin
                r_prod[k] <= '0;
            end
        end else begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_pv <= r_v3;
            if (w_accept) begin
                r_prod    <= w_prod;
                r_bias_s1 <= r_act_b;
            end
            if (r_v1) r_sum  <= w_sum;
            if (r_v2) r_relu <= w_relu;
            if (r_v3) r_pix  <= w_sat;
            if (io_bus.win_valid && !r_cfg_done && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign io_bus.cfg_done  = r_cfg_done;
    assign io_bus.loading   = (r_state == ST_LOAD);
    assign io_bus.pix_out   = r_pix;
    assign io_bus.pix_valid = r_pv;
    assign io_bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_cnn_conv3x3_engine.sv
// Self-checking bench for cnn_conv3x3_engine against a plain-arithmetic convolution model
// with a due-cycle queue for the fixed result latency.
module tb_cnn_conv3x3_engine;
    logic clk;
    logic rst_n;

    cnn_conv3x3_engine_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8)) bus ();

    cnn_conv3x3_engine #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .OUT_SHIFT(4)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
    } exp_t;

    int   n_checks;
    int   n_errors;
    int   m_w [9];
    int   m_sh [9];
    int   m_b;
    int   m_idx;
    int   m_drop;
    int   m_last;
    bit   m_done;
    bit   m_load;
    int   cyc;
    exp_t exp_q [$];
    bit   e_v;
    int   e_p;
    int   cw [10];

    // Reference: integer convolution, ReLU, divide by 2^4, clamp to 255.
    function automatic int conv_ref(input logic [71:0] win);
        int s;
        logic [7:0] px;
        s = m_b;
        for (int k = 0; k < 9; k++) begin
            px = win[k*8 +: 8];
            s += int'(px) * m_w[k];
        end
        if (s < 0) return 0;
        s = s / 16;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 9; k++) begin
            m_w[k]  = 0;
            m_sh[k] = 0;
        end
        m_b = 0; m_idx = 0; m_drop = 0; m_last = 0;
        m_done = 0; m_load = 0;
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = '0;
        bus.win_valid = 0; bus.win_in = '0;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, set e_v/e_p.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (bus.win_valid) begin
                if (m_done) exp_q.push_back('{cyc + 3, conv_ref(bus.win_in)});
                else if (m_drop < 65535) m_drop++;
            end
            if (bus.cfg_start) begin
                m_load = 1; m_idx = 0;
            end else if (m_load && bus.cfg_valid) begin
                if (m_idx == 9) begin
                    m_w = m_sh; m_b = int'(bus.cfg_data); m_done = 1; m_load = 0;
                end else begin
                    m_sh[m_idx] = int'(bus.cfg_data); m_idx++;
                end
            end
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e_v = 1; e_p = exp_q[0].val; m_last = e_p;
            void'(exp_q.pop_front());
        end else begin
            e_v = 0; e_p = m_last;
        end
        #1;
    endtask

    task automatic do_load();
        bus.cfg_start = 1; tick(); bus.cfg_start = 0;
        for (int i = 0; i < 10; i++) begin
            bus.cfg_valid = 1; bus.cfg_data = 8'(cw[i]); tick();
        end
        bus.cfg_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.pix_valid, bus.cfg_done, bus.loading} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags got=%b want=000",
                                 {bus.pix_valid, bus.cfg_done, bus.loading});
        end
        n_checks++;
        if (bus.pix_out !== 8'd0 || bus.drop_cnt !== 16'd0) begin
            n_errors++; $display("FAIL reset_data pix=%0d drop=%0d want 0/0",
                                 bus.pix_out, bus.drop_cnt);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        int want;
        for (int c = 0; c < 3; c++) begin
            if (c != 1) begin
                for (int k = 0; k < 9; k++) cw[k] = (c == 0) ? 1 : ((k == 4) ? 127 : 0);
                cw[9] = (c == 0) ? 0 : 127;
                do_load();
                n_checks++;
                if (bus.cfg_done !== 1'b1 || bus.loading !== 1'b0) begin
                    n_errors++; $display("FAIL basic_load%0d done=%b loading=%b want 1/0",
                                         c, bus.cfg_done, bus.loading);
                end
            end
            for (int k = 0; k < 9; k++)
                bus.win_in[k*8 +: 8] = (c == 0) ? 8'd16 : (c == 1) ? 8'd255 : 8'($urandom);
            if (c == 2) bus.win_in[39:32] = 8'd255;
            want = (c == 0) ? 9 : (c == 1) ? 143 : 255;
            bus.win_valid = 1; tick(); bus.win_valid = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                n_checks++;
                if (bus.pix_valid !== e_v || bus.pix_out !== 8'(e_p)) begin
                    n_errors++; $display("FAIL basic_model%0d pv=%b pix=%0d want %b/%0d",
                                         c, bus.pix_valid, bus.pix_out, e_v, e_p);
                end
                if (i == 2) begin
                    n_checks++;
                    if (bus.pix_valid !== 1'b1 || bus.pix_out !== 8'(want)) begin
                        n_errors++; $display("FAIL basic_value%0d pv=%b pix=%0d want 1/%0d",
                                             c, bus.pix_valid, bus.pix_out, want);
                    end
                end
            end
        end
    endtask

    task automatic test_relu();
        for (int k = 0; k < 10; k++) cw[k] = 0;
        cw[0] = -128;
        do_load();
        for (int k = 0; k < 9; k++) bus.win_in[k*8 +: 8] = 8'($urandom);
        bus.win_in[7:0] = 8'd200;
        bus.win_valid = 1; tick(); bus.win_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.pix_valid !== e_v || bus.pix_out !== 8'(e_p)) begin
                n_errors++; $display("FAIL relu_model pv=%b pix=%0d want %b/%0d",
                                     bus.pix_valid, bus.pix_out, e_v, e_p);
            end
            if (i == 2) begin
                n_checks++;
                if (bus.pix_valid !== 1'b1 || bus.pix_out !== 8'd0) begin
                    n_errors++; $display("FAIL relu_value pv=%b pix=%0d want 1/0",
                                         bus.pix_valid, bus.pix_out);
                end
            end
        end
    endtask

    task automatic test_drop();
        rst_n = 0; model_reset(); #2; rst_n = 1;
        for (int i = 0; i < 9; i++) begin
            bus.win_valid = (i < 5);
            for (int k = 0; k < 9; k++) bus.win_in[k*8 +: 8] = 8'($urandom);
            tick();
            n_checks++;
            if (bus.pix_valid !== 1'b0) begin
                n_errors++; $display("FAIL drop_no_output cycle=%0d pv=%b want 0", i, bus.pix_valid);
            end
        end
        n_checks++;
        if (bus.drop_cnt !== 16'd5 || m_drop != 5) begin
            n_errors++; $display("FAIL drop_count got=%0d want 5", bus.drop_cnt);
        end
        for (int k = 0; k < 9; k++) cw[k] = 1;
        cw[9] = 16;
        do_load();
        bus.win_in = '0;
        bus.win_valid = 1; tick(); bus.win_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 2) begin
                n_checks++;
                if (bus.pix_valid !== 1'b1 || bus.pix_out !== 8'd1 || e_p != 1) begin
                    n_errors++; $display("FAIL drop_bias_value pv=%b pix=%0d want 1/1",
                                         bus.pix_valid, bus.pix_out);
                end
            end
        end
    endtask

    task automatic test_back_to_back_reload();
        int outs [$];
        int n_win;
        n_win = 0;
        for (int k = 0; k < 9; k++) bus.win_in[k*8 +: 8] = 8'd16;
        for (int c = 0; c < 22; c++) begin
            bus.win_valid = (c <= 16);
            bus.cfg_start = (c == 0);
            bus.cfg_valid = (c >= 1 && c <= 10);
            bus.cfg_data  = (c == 10) ? 8'd0 : 8'd2;
            if (bus.win_valid) n_win++;
            tick();
            n_checks++;
            if (bus.pix_valid !== e_v || bus.pix_out !== 8'(e_p)) begin
                n_errors++; $display("FAIL stream_model c=%0d pv=%b pix=%0d want %b/%0d",
                                     c, bus.pix_valid, bus.pix_out, e_v, e_p);
            end
            if (bus.pix_valid === 1'b1) outs.push_back(int'(bus.pix_out));
        end
        idle_inputs();
        n_checks++;
        if (outs.size() != n_win) begin
            n_errors++; $display("FAIL stream_count got=%0d want %0d", outs.size(), n_win);
        end else begin
            n_checks++;
            if (outs[10] != 10 || outs[11] != 18) begin
                n_errors++; $display("FAIL stream_switch got=%0d,%0d want 10,18",
                                     outs[10], outs[11]);
            end
        end
    endtask

    task automatic test_restart();
        bus.cfg_start = 1; tick(); bus.cfg_start = 0;
        for (int i = 0; i < 4; i++) begin
            bus.cfg_valid = 1; bus.cfg_data = 8'd3; tick();
        end
        n_checks++;
        if (bus.loading !== 1'b1) begin
            n_errors++; $display("FAIL restart_loading got=%b want 1", bus.loading);
        end
        bus.cfg_start = 1; bus.cfg_valid = 1; bus.cfg_data = 8'd99; tick();
        bus.cfg_start = 0;
        for (int i = 0; i < 10; i++) begin
            bus.cfg_data = (i == 9) ? 8'd0 : 8'd1; tick();
        end
        bus.cfg_valid = 0;
        n_checks++;
        if (bus.loading !== 1'b0 || bus.cfg_done !== 1'b1) begin
            n_errors++; $display("FAIL restart_commit loading=%b done=%b want 0/1",
                                 bus.loading, bus.cfg_done);
        end
        for (int k = 0; k < 9; k++) bus.win_in[k*8 +: 8] = 8'd16;
        bus.win_valid = 1; tick(); bus.win_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 2) begin
                n_checks++;
                if (bus.pix_valid !== 1'b1 || bus.pix_out !== 8'd9 || e_p != 9) begin
                    n_errors++; $display("FAIL restart_value pv=%b pix=%0d want 1/9",
                                         bus.pix_valid, bus.pix_out);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            bus.win_valid = 1;
            for (int k = 0; k < 9; k++) bus.win_in[k*8 +: 8] = 8'($urandom);
            tick();
        end
        n_checks++;
        if (bus.pix_valid !== 1'b1 || e_v != 1 || bus.pix_out !== 8'(e_p)) begin
            n_errors++; $display("FAIL midreset_pre pv=%b pix=%0d want 1/%0d",
                                 bus.pix_valid, bus.pix_out, e_p);
        end
        rst_n = 0; model_reset();
        #1;
        n_checks++;
        if (bus.pix_valid !== 1'b0 || bus.cfg_done !== 1'b0 || bus.pix_out !== 8'd0) begin
            n_errors++; $display("FAIL midreset_now pv=%b done=%b pix=%0d want 0/0/0",
                                 bus.pix_valid, bus.cfg_done, bus.pix_out);
        end
        bus.win_valid = 0;
        tick(); tick();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.pix_valid !== 1'b0 || bus.drop_cnt !== 16'd0) begin
                n_errors++; $display("FAIL midreset_flush pv=%b drop=%0d want 0/0",
                                     bus.pix_valid, bus.drop_cnt);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 250; c++) begin
            bus.cfg_start = (c % 50 == 10);
            bus.cfg_valid = (c % 50 >= 11 && c % 50 <= 20);
            bus.cfg_data  = 8'($urandom);
            bus.win_valid = (c < 245) && ($urandom_range(0, 9) < 7);
            for (int k = 0; k < 9; k++) bus.win_in[k*8 +: 8] = 8'($urandom);
            tick();
            n_checks++;
            if (bus.pix_valid !== e_v || bus.pix_out !== 8'(e_p)) begin
                n_errors++; $display("FAIL random c=%0d pv=%b pix=%0d want %b/%0d",
                                     c, bus.pix_valid, bus.pix_out, e_v, e_p);
            end
        end
        idle_inputs();
        n_checks++;
        if (bus.drop_cnt !== 16'(m_drop)) begin
            n_errors++; $display("FAIL random_drop got=%0d want %0d", bus.drop_cnt, m_drop);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        test_reset();
        test_basic();
        test_relu();
        test_drop();
        test_back_to_back_reload();
        test_restart();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
